wb_arbiter_2m: RTL and testbench
================================

Name: wb_arbiter_2m

Overview:
- Two-master Wishbone B3 arbiter in front of the SDRAM controller's single Wishbone slave port.
- Grants the slave to one master for a whole bus cycle, so all beats until that master drops `cyc`.
- Uses round-robin fairness.
- Muxes address, data, select, write-enable and cycle-type signals, and routes `ack` and read data back to the granted master only.
- A watchdog terminates a stalled cycle with an error strobe.

Parameters:
- dw, 32, data bus width in bits (multiple of 8).
- APP_AW, 26, address width in bits.
- TMO_W, 8, width of the watchdog counter.
- TIMEOUT, 200, cycles `stb` may wait without `ack` before abort (1 to 2^TMO_W-1).

Ports:
- wb_clk_i  in  1  clock; everything is rising-edge.
- wb_rst_i  in  1  asynchronous, active-low reset.
- mN_cyc_i  in  1  cycle request; N = 0, 1 for every mN_* port.
- mN_stb_i  in  1  strobe.
- mN_we_i  in  1  write enable.
- mN_addr_i  in  APP_AW  address.
- mN_dat_i  in  dw  write data.
- mN_sel_i  in  dw/8  byte selects.
- mN_cti_i  in  3  cycle type identifier.
- mN_ack_o  out  1  acknowledge to master N.
- mN_err_o  out  1  watchdog abort to master N.
- mN_dat_o  out  dw  read data to master N.
- s_cyc_o  out  1  cycle to slave.
- s_stb_o  out  1  strobe to slave.
- s_we_o  out  1  write enable to slave.
- s_addr_o  out  APP_AW  address to slave.
- s_dat_o  out  dw  write data to slave.
- s_sel_o  out  dw/8  byte selects to slave.
- s_cti_o  out  3  cycle type to slave.
- s_ack_i  in  1  slave acknowledge.
- s_dat_i  in  dw  slave read data.
- gnt_o  out  2  one-hot current grant (bit N = master N).

Behaviour:
- Reset (wb_rst_i=0, asynchronous):
  - State = IDLE, last_gnt = 1 (so m0 wins the first tie), watchdog = 0.
  - All outputs = 0.
  - Reset mid-cycle drops s_cyc_o/s_stb_o immediately; no ack or err is generated.
- FSM states: IDLE, GNT0, GNT1. State and last_gnt are registered.
- IDLE:
  - s_cyc_o = s_stb_o = 0.
  - Only one mN_cyc_i high → GNTN next edge.
  - Both high → master ≠ last_gnt wins.
  - Neither → stay IDLE.
  - Arbitration latency: one clock from `cyc` asserted to s_cyc_o.
- GNTN:
  - Combinational mux: s_cyc_o/stb/we/addr/dat/sel/cti = master N's inputs.
  - mN_ack_o = s_ack_i; mN_dat_o = s_dat_i.
  - The other master's ack/err = 0 and its dat_o = 0.
  - gnt_o bit N = 1.
  - Exit when mN_cyc_i = 0 at a clock edge → IDLE, and last_gnt = N.
  - A one-cycle IDLE gap always separates grants.
  - Grant is never preempted. A burst with cti 010 … 111 runs to completion, including `stb` gaps within `cyc`.
- Watchdog (counter width TMO_W):
  - Clears in IDLE, and on any cycle where s_ack_i = 1 or mN_stb_i = 0.
  - Increments while granted with mN_stb_i = 1 and s_ack_i = 0.
  - When it reaches TIMEOUT: pulse mN_err_o = 1 for exactly one cycle, force s_cyc_o = s_stb_o = 0 from the next cycle, and go to IDLE with last_gnt = N.
  - If s_ack_i arrives in the same cycle the count reaches TIMEOUT, the ack wins: no err, and the counter clears.
- Master behaviour after abort:
  - An aborted master holding `cyc` high is re-granted normally after the IDLE cycle.
  - If the other master is also requesting, the other master is granted first.
- Error exclusivity: mN_ack_o and mN_err_o are never high in the same cycle.
- s_ack_i asserted while in IDLE is ignored; it is not forwarded.
- Widths:
  - All datapath muxes are pass-through; no width conversion.
  - The counter saturates and does not wrap (TIMEOUT < 2^TMO_W).

Test Plan:
- Single master: m0 does a classic write to addr 0x0000100, dat 0xA5A5A5A5, sel 0xF, cti 000. s_cyc_o rises 1 clock after m0_cyc_i. Slave acks after 3 cycles → m0_ack_o for 1 cycle, gnt_o = 01. m0 drops cyc → gnt_o = 00 next clock.
- Simultaneous requests after reset: m0 and m1 both raise cyc → m0 granted first. While m0 is active, m1 gets no ack. After m0 releases: 1 IDLE cycle, then gnt_o = 10. A further tie → m0 granted.
- Burst hold: m1 performs a 4-beat incrementing read (cti 010,010,010,111; addr 0x40, 0x41, 0x42, 0x43) while m0 requests throughout. m1 keeps the grant for all 4 acks, m1_dat_o matches s_dat_i, then m0 is granted.
- Watchdog: TIMEOUT = 5, m0 stb high, slave never acks → m0_err_o pulses on the 5th waiting cycle, then s_cyc_o = 0 and state is IDLE. Repeat with s_ack_i arriving on cycle 5 → ack only, no err.
- Reset mid-burst: wb_rst_i low during beat 2 of an m1 burst → all outputs 0 asynchronously. After release, the next tie grants m0.
- Stray ack: s_ack_i pulsed while IDLE → m0_ack_o = m1_ack_o = 0.

Source files
------------

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone B3 arbiter for the SDRAM controller slave port.
// Holds the grant for a whole bus cycle, uses round-robin on ties, and aborts a stalled cycle.
module wb_arbiter_2m #(
  parameter int dw      = 32,
  parameter int APP_AW  = 26,
  parameter int TMO_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,

  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [APP_AW-1:0] m0_addr_i,
  input  logic [dw-1:0]     m0_dat_i,
  input  logic [dw/8-1:0]   m0_sel_i,
  input  logic [2:0]        m0_cti_i,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic [dw-1:0]     m0_dat_o,

  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [APP_AW-1:0] m1_addr_i,
  input  logic [dw-1:0]     m1_dat_i,
  input  logic [dw/8-1:0]   m1_sel_i,
  input  logic [2:0]        m1_cti_i,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic [dw-1:0]     m1_dat_o,

  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [APP_AW-1:0] s_addr_o,
  output logic [dw-1:0]     s_dat_o,
  output logic [dw/8-1:0]   s_sel_o,
  output logic [2:0]        s_cti_o,
  input  logic              s_ack_i,
  input  logic [dw-1:0]     s_dat_i,

  output logic [1:0]        gnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  // The abort fires on the cycle the counter would reach TIMEOUT.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = {TMO_W{1'b1}};

  state_t           state, state_nxt;
  logic             last_gnt, last_gnt_nxt;
  logic [TMO_W-1:0] wdog, wdog_nxt;

  logic             granted;
  logic             sel_stb;
  logic             wait_cyc;
  logic             timeout;

  function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v);
    sat_inc = (v == TMO_MAX) ? v : v + 1'b1;
  endfunction

  assign granted  = (state == GNT0) || (state == GNT1);
  assign sel_stb  = (state == GNT0) ? m0_stb_i : ((state == GNT1) ? m1_stb_i : 1'b0);
  assign wait_cyc = granted && sel_stb && !s_ack_i;
  // An ack landing on the last waiting cycle takes priority over the abort.
  assign timeout  = wait_cyc && (wdog == TMO_LAST);

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      wdog     <= '0;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
      wdog     <= wdog_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    wdog_nxt     = '0;
    if (wait_cyc && !timeout) wdog_nxt = sat_inc(wdog);
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_nxt = last_gnt ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_nxt = GNT0;
        else if (m1_cyc_i)        state_nxt = GNT1;
      end
      GNT0: begin
        if (!m0_cyc_i || timeout) begin
          state_nxt    = IDLE;
          last_gnt_nxt = 1'b0;
        end
      end
      GNT1: begin
        if (!m1_cyc_i || timeout) begin
          state_nxt    = IDLE;
          last_gnt_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath is a plain mux; everything reads zero while idle or in reset.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_cti_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = '0;
    gnt_o    = 2'b00;
    case (state)
      GNT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_addr_o = m0_addr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_cti_o  = m0_cti_i;
        m0_ack_o = s_ack_i;
        m0_err_o = timeout;
        m0_dat_o = s_dat_i;
        gnt_o    = 2'b01;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_addr_o = m1_addr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_cti_o  = m1_cti_i;
        m1_ack_o = s_ack_i;
        m1_err_o = timeout;
        m1_dat_o = s_dat_i;
        gnt_o    = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Self-checking bench for wb_arbiter_2m: vector table through a scoreboard queue,
// plus hand sequences for burst hold and reset in the middle of a burst.
module tb_wb_arbiter_2m;
  localparam int DW = 32;
  localparam int AW = 26;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_dat, m1_dat;
  logic [3:0]    m0_sel, m1_sel;
  logic [2:0]    m0_cti, m1_cti;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic [DW-1:0] m0_rdat, m1_rdat;
  logic          s_cyc, s_stb, s_we, s_ack;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdat, s_rdat;
  logic [3:0]    s_sel;
  logic [2:0]    s_cti;
  logic [1:0]    gnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_arbiter_2m #(.dw(DW), .APP_AW(AW), .TMO_W(8), .TIMEOUT(5)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
    .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_cti_i(m0_cti),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_dat_o(m0_rdat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
    .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_cti_i(m1_cti),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_dat_o(m1_rdat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_addr_o(s_addr),
    .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_cti_o(s_cti),
    .s_ack_i(s_ack), .s_dat_i(s_rdat), .gnt_o(gnt)
  );

  // in = {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack}
  // ctl = {gnt[1:0], s_cyc, s_stb, m0_ack, m0_err, m1_ack, m1_err}
  typedef struct {
    logic       rst_n;
    logic [4:0] in;
    logic [7:0] ctl;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] ctl;
    logic [AW-1:0] addr;
    logic [DW-1:0] rd0;
    logic [DW-1:0] rd1;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic vec_t mk(input logic r, input logic [4:0] i, input logic [7:0] c);
    vec_t v;
    v.rst_n = r;
    v.in    = i;
    v.ctl   = c;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; s_ack = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, wanted finish before 100000");
    $fatal(1, "bench timeout");
  end

  initial begin
    exp_t e;
    rst_n = 0;
    idle_inputs();
    m0_we = 1; m0_addr = AW'('h0000100); m0_dat = 32'hA5A5A5A5; m0_sel = 4'hF; m0_cti = 3'b000;
    m1_we = 0; m1_addr = AW'('h40);      m1_dat = 32'h5A5A0001; m1_sel = 4'h3; m1_cti = 3'b010;
    s_rdat = 32'hCAFE0000;

    // Single master classic write, then ties after reset, stray ack
    tbl.push_back(mk(1, 5'b00000, 8'b00_00_00_00));
    tbl.push_back(mk(1, 5'b11000, 8'b00_00_00_00));
    tbl.push_back(mk(1, 5'b11000, 8'b01_11_00_00));
    tbl.push_back(mk(1, 5'b11000, 8'b01_11_00_00));
    tbl.push_back(mk(1, 5'b11001, 8'b01_11_10_00));
    tbl.push_back(mk(1, 5'b00000, 8'b01_00_00_00));
    tbl.push_back(mk(1, 5'b00000, 8'b00_00_00_00));
    tbl.push_back(mk(0, 5'b00000, 8'b00_00_00_00));
    tbl.push_back(mk(1, 5'b11110, 8'b00_00_00_00));
    tbl.push_back(mk(1, 5'b11111, 8'b01_11_10_00));
    tbl.push_back(mk(1, 5'b11111, 8'b01_11_10_00));
    tbl.push_back(mk(1, 5'b00110, 8'b01_00_00_00));
    tbl.push_back(mk(1, 5'b00110, 8'b00_00_00_00));
    tbl.push_back(mk(1, 5'b00111, 8'b10_11_00_10));
    tbl.push_back(mk(1, 5'b11000, 8'b10_00_00_00));
    tbl.push_back(mk(1, 5'b11110, 8'b00_00_00_00));
    tbl.push_back(mk(1, 5'b11111, 8'b01_11_10_00));
    tbl.push_back(mk(1, 5'b00000, 8'b01_00_00_00));
    tbl.push_back(mk(1, 5'b00001, 8'b00_00_00_00));
    tbl.push_back(mk(1, 5'b00000, 8'b00_00_00_00));
    // Watchdog abort on the 5th waiting cycle, regrant, then ack wins the race
    tbl.push_back(mk(1, 5'b11000, 8'b00_00_00_00));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 5'b11000, 8'b01_11_00_00));
    tbl.push_back(mk(1, 5'b11000, 8'b01_11_01_00));
    tbl.push_back(mk(1, 5'b11000, 8'b00_00_00_00));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 5'b11000, 8'b01_11_00_00));
    tbl.push_back(mk(1, 5'b11001, 8'b01_11_10_00));
    tbl.push_back(mk(1, 5'b11000, 8'b01_11_00_00));
    tbl.push_back(mk(1, 5'b00000, 8'b01_00_00_00));
    tbl.push_back(mk(1, 5'b00000, 8'b00_00_00_00));
    // Abort while m1 waits: m1 is served before m0 again
    tbl.push_back(mk(1, 5'b11000, 8'b00_00_00_00));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 5'b11100, 8'b01_11_00_00));
    tbl.push_back(mk(1, 5'b11100, 8'b01_11_01_00));
    tbl.push_back(mk(1, 5'b11100, 8'b00_00_00_00));
    tbl.push_back(mk(1, 5'b11110, 8'b10_11_00_00));
    tbl.push_back(mk(1, 5'b11000, 8'b10_00_00_00));
    tbl.push_back(mk(1, 5'b11000, 8'b00_00_00_00));
    tbl.push_back(mk(1, 5'b00000, 8'b01_00_00_00));
    tbl.push_back(mk(1, 5'b00000, 8'b00_00_00_00));

    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      rst_n = tbl[i].rst_n;
      {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack} = tbl[i].in;
      e.idx  = i;
      e.ctl  = tbl[i].ctl;
      e.addr = (tbl[i].ctl[7:6] == 2'b01) ? AW'('h100) :
               (tbl[i].ctl[7:6] == 2'b10) ? AW'('h40) : '0;
      e.rd0  = (tbl[i].ctl[7:6] == 2'b01) ? 32'hCAFE0000 : '0;
      e.rd1  = (tbl[i].ctl[7:6] == 2'b10) ? 32'hCAFE0000 : '0;
      sb.push_back(e);
      @(negedge clk);
      if (sb.size() == 0) begin
        check("scoreboard_empty", 64'(0), 64'(1));
      end else begin
        e = sb.pop_front();
        check($sformatf("row%0d_ctl", e.idx),
              64'({gnt, s_cyc, s_stb, m0_ack, m0_err, m1_ack, m1_err}), 64'(e.ctl));
        check($sformatf("row%0d_addr", e.idx), 64'(s_addr), 64'(e.addr));
        check($sformatf("row%0d_rdat", e.idx), {m0_rdat, m1_rdat}, {e.rd0, e.rd1});
      end
    end

    // Burst hold: m1 four-beat incrementing read with a stb gap, m0 requesting throughout
    @(posedge clk); #1;
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; m1_addr = AW'('h40); m1_cti = 3'b010; s_ack = 0;
    @(negedge clk);
    check("burst_arb_idle", 64'(gnt), 64'(2'b00));
    for (int b = 0; b < 4; b++) begin
      if (b == 2) begin
        @(posedge clk); #1;
        m1_stb = 0; s_ack = 0;
        @(negedge clk);
        check("burst_gap_ctl", 64'({gnt, s_cyc, s_stb, m0_ack, m1_ack}), 64'(6'b10_10_00));
      end
      @(posedge clk); #1;
      m1_stb = 1; m1_addr = AW'('h40 + b); m1_cti = (b == 3) ? 3'b111 : 3'b010;
      s_ack = 1; s_rdat = 32'hD0000000 | b;
      @(negedge clk);
      check($sformatf("burst_beat%0d_ctl", b), 64'({gnt, m0_ack, m1_ack, m0_err, m1_err}),
            64'(6'b10_01_00));
      check($sformatf("burst_beat%0d_rdat", b), {m1_rdat, m0_rdat}, {32'hD0000000 | b, 32'h0});
      check($sformatf("burst_beat%0d_bus", b), 64'({s_addr, s_cti, s_we}),
            64'({AW'('h40 + b), (b == 3) ? 3'b111 : 3'b010, 1'b0}));
    end
    @(posedge clk); #1;
    m1_cyc = 0; m1_stb = 0; s_ack = 0;
    @(negedge clk);
    check("burst_release_gnt", 64'({gnt, s_cyc}), 64'(3'b10_0));
    @(posedge clk); #1;
    @(negedge clk);
    check("burst_gap_idle", 64'(gnt), 64'(2'b00));
    @(posedge clk); #1;
    @(negedge clk);
    check("burst_then_m0_gnt", 64'(gnt), 64'(2'b01));
    check("m0_write_bus", {s_wdat, 4'(s_sel), 1'(s_we), 27'(s_addr)},
          {32'hA5A5A5A5, 4'hF, 1'b1, 27'h100});
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;

    // Reset asserted during beat 2 of an m1 burst
    m1_cyc = 1; m1_stb = 1; m1_addr = AW'('h40); m1_cti = 3'b010;
    @(negedge clk);
    check("rst_burst_idle", 64'(gnt), 64'(2'b00));
    @(posedge clk); #1;
    s_ack = 1; s_rdat = 32'h11110000;
    @(negedge clk);
    check("rst_burst_beat1", 64'({gnt, m1_ack}), 64'(3'b10_1));
    @(posedge clk); #1;
    m1_addr = AW'('h41); s_rdat = 32'h11110001;
    #2 rst_n = 0;
    #1;
    check("rst_async_ctl", 64'({gnt, s_cyc, s_stb, m0_ack, m0_err, m1_ack, m1_err}), 64'(0));
    check("rst_async_data", {m1_rdat, 32'(s_addr)}, 64'(0));
    @(posedge clk); #1;
    rst_n = 1; s_ack = 0;
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    @(negedge clk);
    check("post_rst_idle", 64'(gnt), 64'(2'b00));
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_tie_m0", 64'(gnt), 64'(2'b01));
    @(posedge clk); #1;
    idle_inputs();
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
